// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALU op classes and ALU control codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALU op class plus the R-type funct field to
// the 3-bit ALU control code.
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown functs and the unused aluop 11 fall back to add.
  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALUC_ADD;
          FN_SUB:  alucontrol = ALUC_SUB;
          FN_AND:  alucontrol = ALUC_AND;
          FN_OR:   alucontrol = ALUC_OR;
          FN_SLT:  alucontrol = ALUC_SLT;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle MIPS Moore controller: state register, next-state logic,
// per-state control word and the ALU decoder.
module controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       IorD,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t cur, nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // op is only looked at in DECODE and MEMADR, so it may change freely elsewhere.
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEXEC;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nxt = S_MEMWB;
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEXEC: nxt = S_ADDIWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (cur)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
      end
      S_DECODE: ctrl.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  aludec u_aludec (
    .aluop      (ctrl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Write strobes are gated by reset so nothing is committed while held in reset.
  assign pcEn     = reset & (ctrl.pcwrite | (ctrl.branch & zero));
  assign IRwrite  = reset & ctrl.irwrite;
  assign regwrite = reset & ctrl.regwrite;
  assign memwrite = reset & ctrl.memwrite;
  assign IorD     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrcA  = ctrl.alusrca;
  assign alusrcB  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign state    = cur;

endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for the multicycle controller: walks each
// instruction class through the FSM and compares the full output word per cycle.
module tb_controller;
  import mips_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int testsRun = 0;
  int failCount = 0;

  controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcEn       (pcEn),
    .IorD       (IorD),
    .memwrite   (memwrite),
    .IRwrite    (IRwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrcA    (alusrcA),
    .alusrcB    (alusrcB),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word order: pcEn IorD memwrite IRwrite regdst memtoreg regwrite alusrcA alusrcB pcsrc alucontrol state
  logic [18:0] observed;
  assign observed = {pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA,
                     alusrcB, pcsrc, alucontrol, state};

  localparam logic [18:0] E_FETCH   = {8'b1001_0000, 2'b01, 2'b00, 3'b010, S_FETCH};
  localparam logic [18:0] E_RST     = {8'b0000_0000, 2'b01, 2'b00, 3'b010, S_FETCH};
  localparam logic [18:0] E_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, S_DECODE};
  localparam logic [18:0] E_MEMADR  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, S_MEMADR};
  localparam logic [18:0] E_MEMRD   = {8'b0100_0000, 2'b00, 2'b00, 3'b010, S_MEMRD};
  localparam logic [18:0] E_MEMWB   = {8'b0000_0110, 2'b00, 2'b00, 3'b010, S_MEMWB};
  localparam logic [18:0] E_MEMWR   = {8'b0110_0000, 2'b00, 2'b00, 3'b010, S_MEMWR};
  localparam logic [18:0] E_EXADD   = {8'b0000_0001, 2'b00, 2'b00, 3'b010, S_EXECUTE};
  localparam logic [18:0] E_EXSUB   = {8'b0000_0001, 2'b00, 2'b00, 3'b110, S_EXECUTE};
  localparam logic [18:0] E_EXSLT   = {8'b0000_0001, 2'b00, 2'b00, 3'b111, S_EXECUTE};
  localparam logic [18:0] E_EXAND   = {8'b0000_0001, 2'b00, 2'b00, 3'b000, S_EXECUTE};
  localparam logic [18:0] E_EXOR    = {8'b0000_0001, 2'b00, 2'b00, 3'b001, S_EXECUTE};
  localparam logic [18:0] E_ALUWB   = {8'b0000_1010, 2'b00, 2'b00, 3'b010, S_ALUWB};
  localparam logic [18:0] E_BRTAKEN = {8'b1000_0001, 2'b00, 2'b01, 3'b110, S_BRANCH};
  localparam logic [18:0] E_BRNOT   = {8'b0000_0001, 2'b00, 2'b01, 3'b110, S_BRANCH};
  localparam logic [18:0] E_ADDIEX  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, S_ADDIEXEC};
  localparam logic [18:0] E_ADDIWB  = {8'b0000_0010, 2'b00, 2'b00, 3'b010, S_ADDIWB};
  localparam logic [18:0] E_JUMP    = {8'b1000_0000, 2'b00, 2'b10, 3'b010, S_JUMP};

  task automatic applyStimulus(input logic [5:0] newOp, input logic [5:0] newFunct,
                               input logic newZero);
    op    = newOp;
    funct = newFunct;
    zero  = newZero;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [18:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(OP_LW, 6'b000000, 1'b0);
    #2;
    checkOutput("reset_hold", E_RST);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("first_fetch", E_FETCH);

    // LW, with op scrambled once it is no longer sampled
    tick(); checkOutput("lw_decode", E_DECODE);
    tick(); checkOutput("lw_memadr", E_MEMADR);
    tick(); checkOutput("lw_memrd", E_MEMRD);
    applyStimulus(6'b111111, 6'b100010, 1'b1);
    #1;     checkOutput("lw_memrd_opchg", E_MEMRD);
    tick(); checkOutput("lw_memwb", E_MEMWB);
    tick(); checkOutput("lw_fetch", E_FETCH);

    applyStimulus(OP_RTYPE, FN_SUB, 1'b0);
    tick(); checkOutput("sub_decode", E_DECODE);
    tick(); checkOutput("sub_execute", E_EXSUB);
    tick(); checkOutput("sub_aluwb", E_ALUWB);
    tick(); checkOutput("sub_fetch", E_FETCH);

    applyStimulus(OP_RTYPE, FN_SLT, 1'b0);
    tick(); tick(); checkOutput("slt_execute", E_EXSLT);
    applyStimulus(OP_RTYPE, FN_AND, 1'b0);
    #1;     checkOutput("and_execute", E_EXAND);
    applyStimulus(OP_RTYPE, FN_OR, 1'b0);
    #1;     checkOutput("or_execute", E_EXOR);
    applyStimulus(OP_RTYPE, 6'b111000, 1'b0);
    #1;     checkOutput("badfn_execute", E_EXADD);
    tick(); checkOutput("rtype_aluwb", E_ALUWB);
    tick(); checkOutput("rtype_fetch", E_FETCH);

    applyStimulus(OP_BEQ, 6'b000000, 1'b1);
    tick(); checkOutput("beq_t_decode", E_DECODE);
    tick(); checkOutput("beq_t_branch", E_BRTAKEN);
    zero = 1'b0;
    #1;     checkOutput("beq_zero_drop", E_BRNOT);
    tick(); checkOutput("beq_t_fetch", E_FETCH);

    applyStimulus(OP_BEQ, 6'b000000, 1'b0);
    tick(); tick(); checkOutput("beq_n_branch", E_BRNOT);
    tick(); checkOutput("beq_n_fetch", E_FETCH);

    applyStimulus(OP_J, 6'b000000, 1'b1);
    tick(); checkOutput("j_decode", E_DECODE);
    tick(); checkOutput("j_jump", E_JUMP);
    tick(); checkOutput("j_fetch", E_FETCH);

    applyStimulus(6'b111111, 6'b000000, 1'b1);
    tick(); checkOutput("ill_decode", E_DECODE);
    tick(); checkOutput("ill_fetch", E_FETCH);

    applyStimulus(OP_ADDI, 6'b000000, 1'b0);
    tick(); checkOutput("addi_decode", E_DECODE);
    tick(); checkOutput("addi_exec", E_ADDIEX);
    tick(); checkOutput("addi_wb", E_ADDIWB);
    tick(); checkOutput("addi_fetch", E_FETCH);

    // SW aborted by reset in the middle of MEMWR
    applyStimulus(OP_SW, 6'b000000, 1'b0);
    tick(); checkOutput("sw_decode", E_DECODE);
    tick(); checkOutput("sw_memadr", E_MEMADR);
    tick(); checkOutput("sw_memwr", E_MEMWR);
    #2;
    reset = 1'b0;
    #1;     checkOutput("sw_reset_async", E_RST);
    for (int i = 0; i < 3; i++) begin
      tick(); checkOutput($sformatf("sw_reset_hold%0d", i), E_RST);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;     checkOutput("sw_release_fetch", E_FETCH);
    tick(); checkOutput("sw_release_decode", E_DECODE);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
